// File: rtl/data_mem_io.sv
// Byte-addressed data memory with big-endian 16-bit accesses and a memory-mapped IO window.
// Switch and button inputs are synchronised, output bytes drive LEDs and a scanned 8-digit display.
module data_mem_io #(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DEPTH     = 256,
    parameter int unsigned       N_BTNS    = 5,
    parameter logic [ADDR_W-1:0] SSEG_BASE = 8'h40,
    parameter logic [ADDR_W-1:0] LED_BASE  = 8'h44,
    parameter logic [ADDR_W-1:0] SW_BASE   = 8'h4E,
    parameter logic [ADDR_W-1:0] BTN_ADDR  = 8'h50,
    parameter logic [ADDR_W-1:0] EDGE_ADDR = 8'h51,
    parameter int unsigned       SCAN_W    = 17
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] address,
    input  logic              read_en,
    input  logic              write_en,
    input  logic [15:0]       input_data,
    output logic [15:0]       output_data,
    output logic              read_valid,
    output logic              access_err,
    input  logic [15:0]       SW,
    input  logic [N_BTNS-1:0] BTNS,
    output logic [7:0]        CA,
    output logic [7:0]        AN,
    output logic [15:0]       LED,
    input  logic              debug_mode
);

    localparam int unsigned       IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DepthLim = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {KRam, KUnmap, KSseg, KLed, KSw, KBtn, KEdge} kind_e;

    logic [7:0]        mem_q [DEPTH];
    logic [1:0]        ram_we;

    logic [15:0]       out_q, out_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [3:0][7:0]   sseg_q, sseg_d;
    logic [1:0][7:0]   led_q, led_d;
    logic [15:0]       sw_meta_q;
    logic [1:0][7:0]   sw_mirror_q, sw_mirror_d;
    logic [N_BTNS-1:0] btn_s1_q, btn_s2_q;
    logic [7:0]        btn_mirror_q, btn_mirror_d;
    logic [7:0]        edge_q, edge_d;
    logic [SCAN_W-1:0] scan_q, scan_d;

    logic [ADDR_W-1:0] lane_addr  [2];
    logic [7:0]        lane_wdata [2];
    kind_e             lane_kind  [2];
    logic              wr_ok;
    logic              ro_hit;
    logic              unmap_hit;
    logic              edge_clr;
    logic [N_BTNS-1:0] btn_rise;

    function automatic kind_e classify(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] sseg_off;
        logic [ADDR_W-1:0] led_off;
        logic [ADDR_W-1:0] sw_off;
        kind_e             k;
        sseg_off = a - SSEG_BASE;
        led_off  = a - LED_BASE;
        sw_off   = a - SW_BASE;
        if (sseg_off < ADDR_W'(4))        k = KSseg;
        else if (led_off < ADDR_W'(2))    k = KLed;
        else if (sw_off < ADDR_W'(2))     k = KSw;
        else if (a == BTN_ADDR)           k = KBtn;
        else if (a == EDGE_ADDR)          k = KEdge;
        else if ({1'b0, a} < DepthLim)    k = KRam;
        else                              k = KUnmap;
        return k;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a, input kind_e k);
        logic [ADDR_W-1:0] off_s;
        logic [ADDR_W-1:0] off_l;
        logic [ADDR_W-1:0] off_w;
        logic [7:0]        rd;
        off_s = a - SSEG_BASE;
        off_l = a - LED_BASE;
        off_w = a - SW_BASE;
        case (k)
            KRam:    rd = mem_q[a[IdxW-1:0]];
            KSseg:   rd = sseg_q[off_s[1:0]];
            KLed:    rd = led_q[off_l[0]];
            KSw:     rd = sw_mirror_q[off_w[0]];
            KBtn:    rd = btn_mirror_q;
            KEdge:   rd = edge_q;
            default: rd = 8'h00;
        endcase
        return rd;
    endfunction

    // Low byte of a pair wraps to byte 0 at the top of the address space.
    assign lane_addr[0]  = address;
    assign lane_addr[1]  = address + ADDR_W'(1);
    assign lane_wdata[0] = input_data[15:8];
    assign lane_wdata[1] = input_data[7:0];
    assign lane_kind[0]  = classify(lane_addr[0]);
    assign lane_kind[1]  = classify(lane_addr[1]);

    assign wr_ok    = write_en & ~read_en;
    assign btn_rise = btn_s1_q & ~btn_s2_q;
    assign edge_clr = read_en & ~debug_mode &
                      ((lane_kind[0] == KEdge) | (lane_kind[1] == KEdge));

    always_comb begin
        sseg_d         = sseg_q;
        led_d          = led_q;
        sw_mirror_d    = sw_mirror_q;
        btn_mirror_d   = btn_mirror_q;
        edge_d         = edge_q;
        ram_we         = 2'b00;
        ro_hit         = 1'b0;
        unmap_hit      = 1'b0;

        // Mirrors load the first sync stage so they land together with the second stage.
        if (!debug_mode) begin
            sw_mirror_d[0] = sw_meta_q[15:8];
            sw_mirror_d[1] = sw_meta_q[7:0];
            btn_mirror_d   = 8'(btn_s1_q);
            edge_d         = (edge_clr ? 8'h00 : edge_q) | 8'(btn_rise);
        end

        for (int l = 0; l < 2; l++) begin
            if (lane_kind[l] == KUnmap) unmap_hit = 1'b1;
            if (lane_kind[l] inside {KSw, KBtn, KEdge}) ro_hit = 1'b1;
            if (wr_ok) begin
                case (lane_kind[l])
                    KRam:  ram_we[l] = 1'b1;
                    KSseg: sseg_d[2'(lane_addr[l] - SSEG_BASE)] = lane_wdata[l];
                    KLed:  led_d[1'(lane_addr[l] - LED_BASE)] = lane_wdata[l];
                    KSw:   if (debug_mode) sw_mirror_d[1'(lane_addr[l] - SW_BASE)] = lane_wdata[l];
                    KBtn:  if (debug_mode) btn_mirror_d = lane_wdata[l];
                    KEdge: if (debug_mode) edge_d = lane_wdata[l];
                    default: ;
                endcase
            end
        end

        valid_d = read_en;
        out_d   = out_q;
        if (read_en) begin
            out_d = {rd_byte(lane_addr[0], lane_kind[0]), rd_byte(lane_addr[1], lane_kind[1])};
        end
        err_d = (read_en & write_en) |
                ((read_en | write_en) & unmap_hit) |
                (write_en & ~debug_mode & ro_hit);
    end

    always_ff @(posedge CLK) begin
        for (int l = 0; l < 2; l++) begin
            if (ram_we[l]) mem_q[lane_addr[l][IdxW-1:0]] <= lane_wdata[l];
        end
    end

    assign scan_d = scan_q + SCAN_W'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q        <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            sseg_q       <= '0;
            led_q        <= '0;
            sw_meta_q    <= '0;
            sw_mirror_q  <= '0;
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            btn_mirror_q <= '0;
            edge_q       <= '0;
            scan_q       <= '0;
        end else begin
            out_q        <= out_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            sseg_q       <= sseg_d;
            led_q        <= led_d;
            sw_meta_q    <= SW;
            sw_mirror_q  <= sw_mirror_d;
            btn_s1_q     <= BTNS;
            btn_s2_q     <= btn_s1_q;
            btn_mirror_q <= btn_mirror_d;
            edge_q       <= edge_d;
            scan_q       <= scan_d;
        end
    end

    assign output_data = out_q;
    assign read_valid  = valid_q;
    assign access_err  = err_q;
    assign LED         = {led_q[0], led_q[1]};

    // Display scan: one digit per refresh slot, active-low anodes and cathodes.
    logic [31:0] sseg_value;
    logic [2:0]  digit;
    logic [4:0]  nib_lsb;
    logic [3:0]  nibble;
    logic [6:0]  seg7;

    assign sseg_value = {sseg_q[0], sseg_q[1], sseg_q[2], sseg_q[3]};
    assign digit      = scan_q[SCAN_W-1 -: 3];
    assign nib_lsb    = {digit, 2'b00};
    assign nibble     = sseg_value[nib_lsb +: 4];

    always_comb begin
        seg7 = 7'h00;
        case (nibble)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    end

    assign CA = {1'b1, ~seg7};
    assign AN = ~(8'b1 << digit);

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
Parametrised, registered successor to the board data memory. It is a byte-addressed RAM with big-endian two-byte accesses and a memory-mapped IO window. Switch and button inputs are synchronised, and button rising edges are latched sticky and cleared on read. Seven-segment and LED output bytes are mirrored to the board through an internal ssegx8. It sits between the CPU load/store stage and the board IO pins. Reads return after one clock with a valid strobe, and illegal accesses raise an error strobe.

Parameters:
ADDR_W, 8, address width; byte address space is 2^ADDR_W
DEPTH, 256, implemented bytes (<= 2^ADDR_W); addresses >= DEPTH are unmapped
N_BTNS, 5, button count (<= 8)
SSEG_BASE, 8'h40, first of 4 seven-segment bytes (big-endian, byte 0 = VALUE[31:24])
LED_BASE, 8'h44, first of 2 LED bytes (LED[15:8] = byte 0)
SW_BASE, 8'h4E, first of 2 read-only switch bytes
BTN_ADDR, 8'h50, read-only level byte {zero pad, btn_sync}
EDGE_ADDR, 8'h51, read-only sticky rising-edge byte, clear-on-read

Ports:
CLK  in  1  system clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
address  in  ADDR_W  byte address of the high byte; low byte at (address+1) mod 2^ADDR_W
read_en  in  1  read request, sampled at CLK edge
write_en  in  1  write request, sampled at CLK edge
input_data  in  16  write data, [15:8] -> address, [7:0] -> address+1
output_data  out  16  registered read data
read_valid  out  1  one-cycle pulse, output_data valid
access_err  out  1  one-cycle pulse on masked/unmapped/colliding access
SW  in  16  board switches (asynchronous)
BTNS  in  N_BTNS  board buttons (asynchronous)
CA  out  8  seven-segment cathodes (from ssegx8)
AN  out  8  seven-segment anodes (from ssegx8)
LED  out  16  board LEDs
debug_mode  in  1  freeze inputs, allow write injection into read-only bytes

Behaviour:
- Reset (RST_N low, asynchronous): output_data=0, read_valid=0, access_err=0.
  - Also cleared: SSEG/LED bytes, synchroniser flops, edge byte. LED=0 and ssegx8 VALUE=0.
  - General RAM bytes are not reset; their contents are don't-care until written.
- Read: read_en=1 at edge N -> output_data={mem[a],mem[a+1]} and read_valid=1 after edge N, for one cycle. output_data holds its value until the next read.
- Write: write_en=1 at edge N -> bytes updated at edge N. A read of the same address at N+1 returns the new data.
- Read and write in the same cycle: the read is performed, the write is dropped, and access_err pulses.
- Address wrap: address=2^ADDR_W-1 pairs with byte 0, for both read and write.
- Unmapped byte (>= DEPTH): reads as 8'h00, writes are ignored, access_err pulses.
- Read-only bytes (SW_BASE, SW_BASE+1, BTN_ADDR, EDGE_ADDR), when debug_mode=0:
  - Masking is per byte: the writable byte of the pair is still written, the read-only byte is unchanged.
  - access_err pulses.
- Inputs:
  - SW and BTNS pass through a 2-flop synchroniser; switch and button bytes reflect the sync outputs.
  - Input to visible-on-read latency: 2 edges to the sync output, plus 1 for the read.
- Edge byte:
  - Bit i sets on a btn_sync[i] 0->1 transition.
  - Cleared at the edge where a read covering EDGE_ADDR is accepted; the read returns the pre-clear value.
  - A new edge in the same cycle as the clear wins: the bit stays set.
- debug_mode=1:
  - Synchronisers keep running, but the SW/BTN mirror bytes and the edge byte hold their values.
  - Reads do not clear the edge byte.
  - Writes to read-only bytes succeed without access_err. Debug-written values persist until debug_mode falls, after which the mirrors resume tracking on the next edge.
- Outputs:
  - LED and ssegx8 VALUE are driven combinationally from the registered output bytes.
  - A write becomes visible on LED the cycle after the edge.

Test Plan:
- Reset mid-operation: write 16'hBEEF @8'h44, assert RST_N=0 between edges -> LED=0, read_valid=0 immediately. After release, a read @8'h44 returns 16'h0000.
- Write 16'h1234 @8'h10, read @8'h10 -> output_data=16'h1234 with read_valid one cycle later. Write 16'hA55A @8'hFF, read @8'hFF -> 16'hA55A, with mem[0]=8'h5A.
- SW=16'hC3F0 held 3 cycles, read @8'h4E -> 16'hC3F0. Write 16'h0000 @8'h4D -> mem[4D]=0, 4E unchanged, access_err=1.
- Pulse BTNS[2] high 4 cycles, read @8'h50 -> low byte 8'h04 then cleared. Re-read -> 8'h00. Edge arriving on the clearing cycle -> bit remains 1.
- read_en=write_en=1 @8'h20 -> old data returned, write dropped, access_err=1 for exactly one cycle.
- debug_mode=1: write 16'h00FF @8'h4E -> reads 16'h00FF, no access_err, toggling SW ignored. Drop debug_mode -> mirror tracks SW within 1 edge.
